// File: rtl/ram_loader_if.sv
// Bus bundle for ram_loader: serial write-engine control plus the ROM-style read port.
// The master drives load and read requests; the slave returns read data and status.
interface ram_loader_if #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned ADDR_WIDTH = 2
) ();
   logic                  start;
   logic                  bit_in;
   logic                  bit_valid;
   logic [ADDR_WIDTH-1:0] address;
   logic [DATA_WIDTH-1:0] data_out;
   logic                  busy;
   logic                  done;

   modport master (
      output start, bit_in, bit_valid, address,
      input  data_out, busy, done
   );

   modport slave (
      input  start, bit_in, bit_valid, address,
      output data_out, busy, done
   );
endinterface

// File: rtl/ram_loader.sv
// Small synchronous RAM loaded by a serial MSB-first write engine; its read port matches the
// 4x4 ROM (registered, one clock of latency) so a loaded block can stand in for the ROM.
module ram_loader #(
   parameter int unsigned DATA_WIDTH = 4,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input logic         clk,
   input logic         rst_n,
   ram_loader_if.slave bus
);
   localparam int unsigned CntW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

   state_e                state_q;
   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] shreg_q;
   logic [CntW-1:0]       bitcnt_q;
   logic [ADDR_WIDTH-1:0] waddr_q;
   logic [DATA_WIDTH-1:0] data_out_q;
   logic                  busy_q;
   logic                  done_q;
   logic [DATA_WIDTH-1:0] word;

   assign word = {shreg_q[DATA_WIDTH-2:0], bus.bit_in};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= StIdle;
         shreg_q    <= '0;
         bitcnt_q   <= '0;
         waddr_q    <= '0;
         data_out_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         // Nonblocking read alongside the write gives read-before-write on a shared address.
         data_out_q <= mem_q[bus.address];
         unique case (state_q)
            StIdle, StDone: begin
               if (bus.start) begin
                  state_q  <= StShift;
                  bitcnt_q <= '0;
                  waddr_q  <= '0;
                  busy_q   <= 1'b1;
                  done_q   <= 1'b0;
               end
            end
            StShift: begin
               if (bus.bit_valid) begin
                  shreg_q <= word;
                  if (bitcnt_q == CntW'(DATA_WIDTH - 1)) begin
                     mem_q[waddr_q] <= word;
                     bitcnt_q       <= '0;
                     waddr_q        <= waddr_q + 1'b1;
                     if (waddr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                        state_q <= StDone;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                     end
                  end else begin
                     bitcnt_q <= bitcnt_q + 1'b1;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign bus.data_out = data_out_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
endmodule

// File: tb/tb_ram_loader.sv
// Randomized self-checking bench for ram_loader: a word-level memory model predicts read data,
// busy and done from the count of valid serial bits seen since start.
module tb_ram_loader;
   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   ram_loader_if #(.DATA_WIDTH(4), .ADDR_WIDTH(2)) bus ();

   ram_loader #(
      .DATA_WIDTH(4),
      .DEPTH     (4),
      .ADDR_WIDTH(2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   logic [3:0]  exp_mem [4];
   logic        exp_done = 1'b0;

   task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) exp_mem[i] = 4'h0;
      exp_done = 1'b0;
      check_val("rst_busy", bus.busy, 0);
      check_val("rst_done", bus.done, 0);
      check_val("rst_dout", bus.data_out, 0);
   endtask

   // words[15:12] is the word for address 0; watch < 0 means a random read address each cycle.
   task automatic do_load(input logic [15:0] words, input int gap_pct, input int start_at,
                          input int abort_at, input int watch, output int edges);
      int  nvalid;
      bit  v;
      bit  pulsed;
      logic [3:0] exp_dout;
      nvalid = 0;
      edges  = 0;
      pulsed = 1'b0;
      bus.start = 1'b1;
      step();
      bus.start = 1'b0;
      exp_done = 1'b0;
      check_val("start_busy", bus.busy, 1);
      check_val("start_done", bus.done, 0);
      while (nvalid < 16) begin
         if (edges >= 400) begin
            check_val("load_timeout", edges, 0);
            return;
         end
         v = ($urandom_range(99) >= gap_pct);
         bus.bit_valid = v;
         bus.bit_in    = v ? words[15-nvalid] : 1'($urandom_range(1));
         bus.address   = (watch >= 0) ? 2'(watch) : 2'($urandom_range(3));
         if (start_at >= 0 && nvalid == start_at && !pulsed) begin
            bus.start = 1'b1;
            pulsed    = 1'b1;
         end
         exp_dout = exp_mem[bus.address];
         step();
         edges++;
         bus.start     = 1'b0;
         bus.bit_valid = 1'b0;
         if (v) begin
            nvalid++;
            if (nvalid % 4 == 0) exp_mem[nvalid/4-1] = words[15-4*(nvalid/4-1) -: 4];
         end
         check_val("load_dout", bus.data_out, exp_dout);
         if (nvalid == 16) begin
            exp_done = 1'b1;
            check_val("end_busy", bus.busy, 0);
            check_val("end_done", bus.done, 1);
         end else begin
            check_val("mid_busy", bus.busy, 1);
            check_val("mid_done", bus.done, 0);
         end
         if (abort_at >= 0 && nvalid == abort_at) return;
      end
   endtask

   task automatic read_all();
      for (int a = 0; a < 4; a++) begin
         bus.address = 2'(a);
         step();
         check_val($sformatf("read%0d", a), bus.data_out, exp_mem[a]);
         check_val("read_done", bus.done, exp_done);
         check_val("read_busy", bus.busy, 0);
      end
   endtask

   initial begin
      int edges;
      bus.start     = 1'b0;
      bus.bit_in    = 1'b0;
      bus.bit_valid = 1'b0;
      bus.address   = '0;
      step();
      do_reset();

      do_load(16'b0011_1000_1111_0110, 0, -1, -1, 1, edges);
      check_val("done_latency", edges, 16);
      read_all();

      do_reset();
      do_load(16'b0011_1000_1111_0110, 50, -1, -1, -1, edges);
      read_all();

      do_reset();
      do_load(16'b0011_1000_1111_0110, 0, 6, -1, -1, edges);
      check_val("start_ignored_latency", edges, 16);
      read_all();

      do_load(16'b1010_1010_1010_1010, 30, -1, 9, -1, edges);
      do_reset();
      read_all();
      do_load(16'b1010_1010_1010_1010, 30, -1, -1, -1, edges);
      read_all();

      do_load(16'b0001_0010_0100_1000, 40, -1, -1, -1, edges);
      read_all();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
